// File: rtl/fib_term_fifo_if.sv
// Handshake/status bundle between fib_term_fifo and its driver/reader.
// The design side uses the slave modport.
interface fib_term_fifo_if #(
  parameter int N = 6
);
  logic         start;
  logic [N-1:0] fn;
  logic         rd_en;
  logic [N-1:0] rd_data;
  logic         rd_valid;
  logic         busy;
  logic         done;
  logic [7:0]   term_count;
  logic         wrapped;
  logic         overflow;
  logic         err;
  logic [7:0]   err_index;

  modport master (
    output start, fn, rd_en,
    input  rd_data, rd_valid, busy, done, term_count, wrapped, overflow, err, err_index
  );

  modport slave (
    input  start, fn, rd_en,
    output rd_data, rd_valid, busy, done, term_count, wrapped, overflow, err, err_index
  );
endinterface

// File: rtl/fib_term_fifo.sv
// Captures MAX_TERMS Fibonacci terms into a show-ahead FIFO with wrap/overflow status.
// Optional recurrence checker enabled by defining FIB_TERM_CHECK_EN.
module fib_term_fifo #(
  parameter int N         = 6,
  parameter int DEPTH     = 8,
  parameter int MAX_TERMS = 16
) (
  input logic           clock,
  input logic           reset,
  fib_term_fifo_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]   state;
  logic [N-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]  occ;
  logic [7:0]   term_count;
  logic [N-1:0] prev;
  logic         wrapped_q;
  logic         overflow_q;

  logic capturing;
  logic launch;
  logic pop;
  logic full;
  logic push;
  logic last;

  always_comb begin
    capturing = (state == CAPTURE);
    launch    = bus.start && !capturing;
    pop       = bus.rd_en && (occ != '0);
    full      = (occ == (AW+1)'(DEPTH));
    // A full FIFO still accepts a term when the reader frees a slot on the same edge.
    push      = capturing && (!full || pop);
    last      = (term_count == 8'(MAX_TERMS - 1));
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr] <= bus.fn;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      term_count <= '0;
      prev       <= '0;
      wrapped_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (launch) begin
      state      <= CAPTURE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      term_count <= '0;
      prev       <= '0;
      wrapped_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      if (capturing) begin
        prev <= bus.fn;
        if ((term_count != 8'd0) && (bus.fn < prev)) begin
          wrapped_q <= 1'b1;
        end
        if (full && !pop) begin
          overflow_q <= 1'b1;
        end
        if (term_count < 8'(MAX_TERMS)) begin
          term_count <= term_count + 8'd1;
        end
        if (last) begin
          state <= DONE;
        end
      end
    end
  end

`ifdef FIB_TERM_CHECK_EN
  logic [N-1:0] prev2;
  logic [N-1:0] expect_sum;
  logic         err_q;
  logic [7:0]   err_index_q;

  always_comb begin
    expect_sum = prev + prev2;
  end

  always_ff @(posedge clock) begin
    if (reset || launch) begin
      prev2       <= '0;
      err_q       <= 1'b0;
      err_index_q <= '0;
    end else if (capturing) begin
      prev2 <= prev;
      if ((term_count >= 8'd2) && (bus.fn != expect_sum) && !err_q) begin
        err_q       <= 1'b1;
        err_index_q <= term_count;
      end
    end
  end

  assign bus.err       = err_q;
  assign bus.err_index = err_index_q;
`else
  assign bus.err       = 1'b0;
  assign bus.err_index = '0;
`endif

  // Gate the head with occupancy so a flushed/reset FIFO presents zero.
  assign bus.rd_data    = (occ != '0) ? mem[rd_ptr] : '0;
  assign bus.rd_valid   = (occ != '0);
  assign bus.busy       = capturing;
  assign bus.done       = (state == DONE);
  assign bus.term_count = term_count;
  assign bus.wrapped    = wrapped_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_fib_term_fifo.sv
// Directed bench for fib_term_fifo (N=6, DEPTH=8, MAX_TERMS=16).
// Checker expectations follow FIB_TERM_CHECK_EN when defined.
module tb_fib_term_fifo;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fib_term_fifo_if #(.N(6)) bus ();

  fib_term_fifo #(.N(6), .DEPTH(8), .MAX_TERMS(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] ref_terms [16] = '{6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34,
                                 6'd55, 6'd25, 6'd16, 6'd41, 6'd57, 6'd34, 6'd27, 6'd61};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input logic rd);
    bus.start = 1'b1;
    bus.rd_en = rd;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [30:0] all_out;
    reset = 1'b1; bus.start = 1'b0; bus.rd_en = 1'b0; bus.fn = '0;
    step(); step();
    reset = 1'b0;
    all_out = {bus.rd_data, bus.rd_valid, bus.busy, bus.done, bus.term_count,
               bus.wrapped, bus.overflow, bus.err, bus.err_index};
    vectors++;
    if (all_out !== 31'd0) begin
      miscompares++; $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
  endtask

  task automatic test_normal_run();
    logic [5:0] got [$];
    start_run(1'b1);
    for (int k = 0; k < 16; k++) begin
      bus.fn = ref_terms[k];
      bus.rd_en = 1'b1;
      if (bus.rd_valid === 1'b1) got.push_back(bus.rd_data);
      step();
      if (k == 8) begin
        vectors++;
        if (bus.wrapped !== 1'b0) begin
          miscompares++; $display("FAIL wrapped_before_k9 got=%b exp=0", bus.wrapped);
        end
      end
      if (k == 9) begin
        vectors++;
        if (bus.wrapped !== 1'b1) begin
          miscompares++; $display("FAIL wrapped_at_k9 got=%b exp=1", bus.wrapped);
        end
      end
    end
    vectors++;
    if ({bus.done, bus.busy, bus.term_count, bus.overflow} !== {1'b1, 1'b0, 8'd16, 1'b0}) begin
      miscompares++;
      $display("FAIL normal_status done=%b busy=%b count=%0d ovf=%b exp 1 0 16 0",
               bus.done, bus.busy, bus.term_count, bus.overflow);
    end
    if (bus.rd_valid === 1'b1) got.push_back(bus.rd_data);
    step();
    bus.rd_en = 1'b0;
    vectors++;
    if (got.size() != 16) begin
      miscompares++; $display("FAIL normal_pop_count got=%0d exp=16", got.size());
    end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== ref_terms[i]) begin
        miscompares++; $display("FAIL normal_pop[%0d] got=%0d exp=%0d", i, got[i], ref_terms[i]);
      end
    end
  endtask

  task automatic test_overflow();
    start_run(1'b0);
    for (int k = 0; k < 16; k++) begin
      bus.fn = ref_terms[k];
      step();
    end
    vectors++;
    if ({bus.overflow, bus.term_count, bus.done} !== {1'b1, 8'd16, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_status ovf=%b count=%0d done=%b exp 1 16 1",
               bus.overflow, bus.term_count, bus.done);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({bus.rd_valid, bus.rd_data} !== {1'b1, ref_terms[i]}) begin
        miscompares++;
        $display("FAIL ovf_drain[%0d] valid=%b data=%0d exp 1 %0d", i, bus.rd_valid, bus.rd_data, ref_terms[i]);
      end
      bus.rd_en = 1'b1;
      step();
    end
    bus.rd_en = 1'b0;
    vectors++;
    if ({bus.rd_valid, bus.rd_data} !== 7'd0) begin
      miscompares++; $display("FAIL ovf_empty valid=%b data=%0d exp 0 0", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_full_pop();
    start_run(1'b0);
    for (int k = 0; k < 16; k++) begin
      bus.fn = ref_terms[k];
      bus.rd_en = (k == 8);
      step();
      if (k == 7 || k == 8) begin
        vectors++;
        if (bus.overflow !== 1'b0) begin
          miscompares++; $display("FAIL fullpop_ovf k=%0d got=%b exp=0", k, bus.overflow);
        end
      end
      if (k == 8) begin
        vectors++;
        if (bus.rd_data !== 6'd2) begin
          miscompares++; $display("FAIL fullpop_head got=%0d exp=2", bus.rd_data);
        end
      end
    end
    bus.rd_en = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b1) begin
      miscompares++; $display("FAIL fullpop_late_ovf got=%b exp=1", bus.overflow);
    end
    for (int i = 1; i < 9; i++) begin
      vectors++;
      if ({bus.rd_valid, bus.rd_data} !== {1'b1, ref_terms[i]}) begin
        miscompares++;
        $display("FAIL fullpop_drain[%0d] valid=%b data=%0d exp 1 %0d", i, bus.rd_valid, bus.rd_data, ref_terms[i]);
      end
      bus.rd_en = 1'b1;
      step();
    end
    bus.rd_en = 1'b0;
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL fullpop_empty got=%b exp=0", bus.rd_valid);
    end
  endtask

  task automatic test_control_corners();
    logic [30:0] all_out;
    start_run(1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.fn = ref_terms[k];
      bus.start = (k == 3);
      step();
      bus.start = 1'b0;
      if (k == 3) begin
        vectors++;
        if ({bus.term_count, bus.busy, bus.rd_valid} !== {8'd4, 1'b1, 1'b1}) begin
          miscompares++;
          $display("FAIL midrun_start count=%0d busy=%b valid=%b exp 4 1 1",
                   bus.term_count, bus.busy, bus.rd_valid);
        end
      end
    end
    vectors++;
    if (bus.term_count !== 8'd5) begin
      miscompares++; $display("FAIL count_k4 got=%0d exp=5", bus.term_count);
    end
    bus.fn = ref_terms[5];
    reset = 1'b1;
    step();
    reset = 1'b0;
    all_out = {bus.rd_data, bus.rd_valid, bus.busy, bus.done, bus.term_count,
               bus.wrapped, bus.overflow, bus.err, bus.err_index};
    vectors++;
    if (all_out !== 31'd0) begin
      miscompares++; $display("FAIL midrun_reset got=%h exp=0", all_out);
    end
    step();
    vectors++;
    if ({bus.busy, bus.done, bus.term_count, bus.rd_valid} !== 11'd0) begin
      miscompares++;
      $display("FAIL idle_hold busy=%b done=%b count=%0d valid=%b exp 0 0 0 0",
               bus.busy, bus.done, bus.term_count, bus.rd_valid);
    end
  endtask

  task automatic test_checker();
    logic [5:0] stream [16];
    logic       exp_err;
    logic [7:0] exp_idx;
`ifdef FIB_TERM_CHECK_EN
    exp_err = 1'b1; exp_idx = 8'd4;
`else
    exp_err = 1'b0; exp_idx = 8'd0;
`endif
    for (int i = 0; i < 16; i++) stream[i] = ref_terms[i];
    stream[4] = 6'd9;
    start_run(1'b1);
    for (int k = 0; k < 16; k++) begin
      bus.fn = stream[k];
      bus.rd_en = 1'b1;
      step();
      if (k == 3) begin
        vectors++;
        if (bus.err !== 1'b0) begin
          miscompares++; $display("FAIL chk_clean_k3 got=%b exp=0", bus.err);
        end
      end
      if (k == 4 || k == 5 || k == 15) begin
        vectors++;
        if ({bus.err, bus.err_index} !== {exp_err, exp_idx}) begin
          miscompares++;
          $display("FAIL chk_k%0d err=%b idx=%0d exp %b %0d", k, bus.err, bus.err_index, exp_err, exp_idx);
        end
      end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_restart();
    vectors++;
    if ({bus.done, bus.wrapped, bus.rd_valid} !== 3'b111) begin
      miscompares++;
      $display("FAIL pre_restart done=%b wrapped=%b valid=%b exp 1 1 1", bus.done, bus.wrapped, bus.rd_valid);
    end
    start_run(1'b0);
    vectors++;
    if ({bus.rd_valid, bus.busy, bus.done, bus.term_count, bus.wrapped,
         bus.overflow, bus.err, bus.err_index} !== {1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL restart_clear valid=%b busy=%b done=%b count=%0d wrap=%b ovf=%b err=%b idx=%0d",
               bus.rd_valid, bus.busy, bus.done, bus.term_count, bus.wrapped,
               bus.overflow, bus.err, bus.err_index);
    end
    for (int k = 0; k < 16; k++) begin
      bus.fn = ref_terms[k];
      step();
    end
    vectors++;
    if ({bus.done, bus.term_count, bus.err, bus.rd_valid, bus.rd_data} !==
        {1'b1, 8'd16, 1'b0, 1'b1, 6'd1}) begin
      miscompares++;
      $display("FAIL restart_run done=%b count=%0d err=%b valid=%b head=%0d exp 1 16 0 1 1",
               bus.done, bus.term_count, bus.err, bus.rd_valid, bus.rd_data);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.rd_en = 1'b0;
    bus.fn    = '0;
    test_reset();
    test_normal_run();
    test_overflow();
    test_full_pop();
    test_control_corners();
    test_checker();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fib_term_fifo.md
Name: fib_term_fifo

Overview:
- Downstream consumer of the Fibonacci term generator.
- Samples the generator's fn output once per clock after a start pulse and counts terms.
- Detects modulo-2^N wrap and buffers terms in a DEPTH-entry FIFO for a slower reader (display/UART stage).
- Reports capture status: busy, done, wrapped, overflow.

Parameters:
N, 6, term width; must match the generator's N.
DEPTH, 8, FIFO entries; power of two, >= 2.
MAX_TERMS, 16, terms sampled per capture run; 1..255.

Ports:
clock  in  1  single system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a capture run.
fn  in  N  current term from the generator. The generator updates on the falling edge, so fn is stable at the rising edge.
rd_en  in  1  reader pops the head entry.
rd_data  out  N  FIFO head entry; valid when rd_valid=1.
rd_valid  out  1  FIFO not empty.
busy  out  1  high in CAPTURE.
done  out  1  high in DONE.
term_count  out  8  terms sampled this run.
wrapped  out  1  sticky; a term smaller than its predecessor was seen.
overflow  out  1  sticky; a term was dropped because the FIFO was full.
err  out  1  sticky recurrence-check failure (see Optional Feature).
err_index  out  8  term_count value of the first failing term.

Behaviour:
Reset and start:
- Reset (synchronous, active-high, any state): state=IDLE; FIFO pointers and occupancy=0.
- Reset values: every output=0, including rd_data=0.
- Reset mid-run discards all buffered terms.

State machine: IDLE, CAPTURE, DONE.
- IDLE: start=1 -> CAPTURE.
- On that start edge: flush FIFO; clear term_count, wrapped, overflow, err, err_index; clear prev register.
- CAPTURE: start ignored. Each rising edge samples fn as term k (k = term_count before increment), then term_count++.
- CAPTURE -> DONE on the edge that samples term MAX_TERMS; busy drops and done rises on the same edge.
- DONE: holds all status. start=1 -> CAPTURE with the same flush/clear as from IDLE. FIFO remains readable in IDLE and DONE.

Push rules (CAPTURE only):
- Push the sampled term if occupancy<DEPTH.
- Also push at occupancy==DEPTH when a pop occurs on the same edge; net occupancy is unchanged and there is no overflow.
- If full with no pop: drop the term, set overflow. The term is still counted and still checked.

Pop rules:
- rd_en=1 with rd_valid=1 pops on the edge.
- rd_en with the FIFO empty is ignored.
- A pop on the same edge as a push into an empty FIFO: the push wins; occupancy becomes 1.

Read data:
- rd_data is show-ahead: it always reflects the head entry combinationally from storage.
- Pointers wrap modulo DEPTH.

Wrap and count:
- wrapped is set when k>=1 and fn < prev, where prev is the previous sampled term.
- Comparison is unsigned N-bit. prev is updated on every sample.
- term_count saturates at MAX_TERMS; no other arithmetic widens beyond N bits.

Optional Feature:
Macro: FIB_TERM_CHECK_EN
- Defined: keep the two previous terms. For k>=2, compare fn against (prev1+prev2) mod 2^N.
- On the first mismatch set err=1 and err_index=k. err and err_index are sticky until reset/start; later mismatches are not recorded.
- Not defined: no checker logic; err and err_index are tied to 0.

Test Plan:
Reference stream: bench drives fn from a behavioural mod-64 Fibonacci model: 1,2,3,5,8,13,21,34,55,25,16,41,57,34,27,61. N=6, DEPTH=8, MAX_TERMS=16.
1. Normal run: reset, start, rd_en held 1 -> reader gets all 16 terms in order; overflow=0; wrapped=1 from the edge sampling 25 (k=9); done=1 and term_count=16 after term 16.
2. Overflow: rd_en=0 for the whole run -> FIFO holds 1,2,3,5,8,13,21,34; overflow=1; term_count=16. Draining yields those 8 values, then rd_valid=0.
3. Full + pop: rd_en=0 until occupancy=8, then rd_en=1 for one cycle during CAPTURE -> pops 1, pushes the new term, occupancy stays 8, overflow stays 0.
4. Control corners: start pulsed mid-run -> ignored, term_count continues. Reset asserted at term 5 -> next edge shows all outputs 0, rd_valid=0, state IDLE.
5. Checker (FIB_TERM_CHECK_EN defined): drive 9 instead of 8 at k=4 -> err=1, err_index=4. The later mismatch at k=5 (13 vs 14) leaves err_index=4. Same stimulus without the macro -> err=0.
6. Restart from DONE: start -> FIFO flushed, rd_valid=0, all status cleared, new run captures normally.
